// File: rtl/uartrx_start_bit_filter.sv
// Multi-channel UART start-bit detector: synchronise, detect the idle-to-active edge, qualify it, pulse, then hold busy until frame_done.
// Optional per-channel glitch counters are enabled with `define UARTRX_GLITCH_COUNT_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | armed, waiting for a fresh idle-to-active edge on the line
// QUAL  | edge seen, counting consecutive active samples
// BUSY  | start confirmed, channel locked until frame_done or disable
module uartrx_start_bit_filter #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned QUAL_CYCLES = 4,
   parameter logic        IDLE_LEVEL  = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] serial_in,
   input  logic [NUM_CH-1:0] enable,
   input  logic [NUM_CH-1:0] frame_done,
   output logic [NUM_CH-1:0] start_bit_detected,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] line_sync
`ifdef UARTRX_GLITCH_COUNT_EN
   ,
   output logic [NUM_CH*8-1:0] glitch_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(QUAL_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUAL_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_QUAL = 2'd1,
      ST_BUSY = 2'd2
   } state_t;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   prev_q;
      logic                   s_cur;
      logic                   edge_det;
      state_t                 state_q;
      state_t                 state_nxt;
      logic [CNT_W-1:0]       cnt_q;
      logic [CNT_W-1:0]       cnt_nxt;
      logic                   pulse_nxt;
      logic                   pulse_q;
      logic                   busy_q;

      assign s_cur    = sync_q[SYNC_STAGES-1];
      assign edge_det = (prev_q == IDLE_LEVEL) && (s_cur != IDLE_LEVEL);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
            prev_q <= IDLE_LEVEL;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in[i]};
            prev_q <= s_cur;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            pulse_q <= pulse_nxt;
            busy_q  <= (state_nxt == ST_BUSY);
         end
      end

      always_comb begin
         state_nxt = state_q;
         cnt_nxt   = cnt_q;
         pulse_nxt = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (enable[i] && edge_det) begin
                  if (QUAL_CYCLES == 1) begin
                     state_nxt = ST_BUSY;
                     pulse_nxt = 1'b1;
                  end else begin
                     state_nxt = ST_QUAL;
                     cnt_nxt   = CNT_ONE;
                  end
               end
            end
            ST_QUAL: begin
               if (!enable[i]) begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = '0;
               end else if (s_cur == IDLE_LEVEL) begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_nxt = ST_BUSY;
                  pulse_nxt = 1'b1;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_q + CNT_ONE;
               end
            end
            ST_BUSY: begin
               // a new edge while locked is simply dropped
               if (!enable[i] || frame_done[i]) begin
                  state_nxt = ST_IDLE;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end

      assign start_bit_detected[i] = pulse_q;
      assign busy[i]               = busy_q;
      assign line_sync[i]          = s_cur;

`ifdef UARTRX_GLITCH_COUNT_EN
      logic       glitch_hit;
      logic [7:0] gcnt_q;

      // only line-caused aborts count, not disable-caused ones
      assign glitch_hit = (state_q == ST_QUAL) && enable[i] && (s_cur == IDLE_LEVEL);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            gcnt_q <= 8'd0;
         end else if (glitch_hit && (gcnt_q != 8'hFF)) begin
            gcnt_q <= gcnt_q + 8'd1;
         end
      end

      assign glitch_cnt[8*i +: 8] = gcnt_q;
`endif
   end

endmodule

// File: tb/tb_uartrx_start_bit_filter.sv
// Self-checking bench: directed steps plus random line activity, two parameterisations
// checked every cycle against a sample-log reference model.
module tb_uartrx_start_bit_filter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] serial_in;
   logic [3:0] enable;
   logic [3:0] frame_done;
   logic [3:0] sbd0, busy0, ls0;
   logic [3:0] sbd1, busy1, ls1;
`ifdef UARTRX_GLITCH_COUNT_EN
   logic [31:0] gc0, gc1;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   uartrx_start_bit_filter u_dut (
      .clk                (clk),
      .rst                (rst),
      .serial_in          (serial_in),
      .enable             (enable),
      .frame_done         (frame_done),
      .start_bit_detected (sbd0),
      .busy               (busy0),
      .line_sync          (ls0)
`ifdef UARTRX_GLITCH_COUNT_EN
      ,
      .glitch_cnt         (gc0)
`endif
   );

   uartrx_start_bit_filter #(.QUAL_CYCLES(1), .SYNC_STAGES(3)) u_dut_fast (
      .clk                (clk),
      .rst                (rst),
      .serial_in          (serial_in),
      .enable             (enable),
      .frame_done         (frame_done),
      .start_bit_detected (sbd1),
      .busy               (busy1),
      .line_sync          (ls1)
`ifdef UARTRX_GLITCH_COUNT_EN
      ,
      .glitch_cnt         (gc1)
`endif
   );

   // reference model: every serial_in value sampled since reset, plus per-channel run/lock state
   logic [3:0] log_q[$];
   int         run    [2][4];
   bit         locked [2][4];
   bit         pulse  [2][4];
   int         gl     [2][4];

   function automatic int sync_depth(input int d);
      return (d == 0) ? 2 : 3;
   endfunction

   function automatic int qual_len(input int d);
      return (d == 0) ? 4 : 1;
   endfunction

   function automatic logic [3:0] sample_at(input int idx);
      if (idx < 0) return 4'hF;
      return log_q[idx];
   endfunction

   task automatic model_reset();
      log_q.delete();
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 4; c++) begin
            run[d][c]    = 0;
            locked[d][c] = 1'b0;
            pulse[d][c]  = 1'b0;
            gl[d][c]     = 0;
         end
   endtask

   // s before an edge is the sample taken SYNC edges earlier; p one further back
   task automatic model_edge();
      int m;
      logic [3:0] sv, pv;
      bit act, fresh;
      m = log_q.size();
      for (int d = 0; d < 2; d++) begin
         sv = sample_at(m - sync_depth(d));
         pv = sample_at(m - sync_depth(d) - 1);
         for (int c = 0; c < 4; c++) begin
            act   = (sv[c] == 1'b0);
            fresh = (pv[c] == 1'b1) && act;
            pulse[d][c] = 1'b0;
            if (locked[d][c]) begin
               if (!enable[c] || frame_done[c]) locked[d][c] = 1'b0;
            end else if (run[d][c] == 0) begin
               if (enable[c] && fresh) run[d][c] = 1;
            end else if (!enable[c]) begin
               run[d][c] = 0;
            end else if (!act) begin
               run[d][c] = 0;
               if (gl[d][c] < 255) gl[d][c]++;
            end else begin
               run[d][c]++;
            end
            if (run[d][c] == qual_len(d)) begin
               pulse[d][c]  = 1'b1;
               locked[d][c] = 1'b1;
               run[d][c]    = 0;
            end
         end
      end
      log_q.push_back(serial_in);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cmp_dut(input int d, input logic [3:0] sbd, input logic [3:0] bsy,
                          input logic [3:0] ls);
      logic [3:0] ep, eb;
      for (int c = 0; c < 4; c++) begin
         ep[c] = pulse[d][c];
         eb[c] = locked[d][c];
      end
      chk((d == 0) ? "d0_pulse" : "d1_pulse", {28'd0, sbd}, {28'd0, ep});
      chk((d == 0) ? "d0_busy"  : "d1_busy",  {28'd0, bsy}, {28'd0, eb});
      chk((d == 0) ? "d0_sync"  : "d1_sync",  {28'd0, ls},
          {28'd0, sample_at(log_q.size() - sync_depth(d))});
   endtask

   task automatic check_all();
      cmp_dut(0, sbd0, busy0, ls0);
      cmp_dut(1, sbd1, busy1, ls1);
`ifdef UARTRX_GLITCH_COUNT_EN
      for (int c = 0; c < 4; c++) begin
         chk("d0_glitch", {24'd0, gc0[8*c +: 8]}, gl[0][c]);
         chk("d1_glitch", {24'd0, gc1[8*c +: 8]}, gl[1][c]);
      end
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   int rem[4];

   initial begin
      rst        = 1'b1;
      serial_in  = 4'hF;
      enable     = 4'hF;
      frame_done = 4'h0;
      model_reset();
      #12;
      chk("rst_pulse", {28'd0, sbd0 | sbd1}, 32'd0);
      chk("rst_busy",  {28'd0, busy0 | busy1}, 32'd0);
      chk("rst_sync",  {24'd0, ls0, ls1}, 32'hFF);
      @(negedge clk);
      rst = 1'b0;

      // idle lines
      repeat (50) begin
         step();
         chk("idle_pulse", {28'd0, sbd0}, 32'd0);
         chk("idle_busy",  {28'd0, busy0}, 32'd0);
         chk("idle_sync",  {28'd0, ls0}, 32'hF);
      end

      // channel 0 held low: pulse after edge 6, busy until frame_done, no re-trigger
      serial_in[0] = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         step();
         chk("ch0_latency", {31'd0, sbd0[0]}, (e == 6) ? 32'd1 : 32'd0);
      end
      step();
      chk("ch0_pulse_once", {31'd0, sbd0[0]}, 32'd0);
      chk("ch0_busy", {31'd0, busy0[0]}, 32'd1);
      repeat (5) step();
      chk("ch0_busy_hold", {31'd0, busy0[0]}, 32'd1);
      frame_done[0] = 1'b1;
      step();
      frame_done[0] = 1'b0;
      chk("ch0_release", {31'd0, busy0[0]}, 32'd0);
      repeat (10) begin
         step();
         chk("ch0_no_rearm", {31'd0, sbd0[0] | busy0[0]}, 32'd0);
      end
      serial_in[0] = 1'b1;
      repeat (4) step();

      // channel 1 glitch of 3 samples
      serial_in[1] = 1'b0;
      repeat (3) step();
      serial_in[1] = 1'b1;
      repeat (8) begin
         step();
         chk("ch1_glitch_nopulse", {31'd0, sbd0[1] | busy0[1]}, 32'd0);
      end
`ifdef UARTRX_GLITCH_COUNT_EN
      chk("ch1_glitch_cnt", {24'd0, gc0[15:8]}, 32'd1);
`endif
      frame_done[1] = 1'b1;
      step();
      frame_done[1] = 1'b0;

      // channels 2 and 3 together
      serial_in[3:2] = 2'b00;
      for (int e = 1; e <= 6; e++) begin
         step();
         chk("ch23_pulse", {30'd0, sbd0[3:2]}, (e == 6) ? 32'd3 : 32'd0);
      end
      step();
      chk("ch23_busy", {30'd0, busy0[3:2]}, 32'd3);
      frame_done[2] = 1'b1;
      step();
      frame_done[2] = 1'b0;
      chk("ch2_only_release", {30'd0, busy0[3:2]}, 32'd2);
      frame_done[3] = 1'b1;
      step();
      frame_done[3] = 1'b0;
      serial_in = 4'hF;
      repeat (4) step();

      // enable dropped mid-qualification
      serial_in[0] = 1'b0;
      repeat (4) step();
      enable[0] = 1'b0;
      repeat (8) begin
         step();
         chk("en_abort", {31'd0, sbd0[0] | busy0[0]}, 32'd0);
      end
      enable[0] = 1'b1;
      repeat (8) begin
         step();
         chk("en_no_rearm", {31'd0, sbd0[0]}, 32'd0);
      end
      serial_in[0] = 1'b1;
      repeat (4) step();

      // asynchronous reset while busy
      serial_in[1] = 1'b0;
      repeat (8) step();
      chk("pre_rst_busy", {31'd0, busy0[1]}, 32'd1);
      serial_in[1] = 1'b1;
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("async_rst_busy", {28'd0, busy0 | busy1}, 32'd0);
      chk("async_rst_sync", {24'd0, ls0, ls1}, 32'hFF);
`ifdef UARTRX_GLITCH_COUNT_EN
      chk("async_rst_gcnt", gc0, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      repeat (3) step();

      // fast instance: pulse after edge 4, then frame_done coincident with a new edge
      serial_in[3] = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         step();
         chk("fast_latency", {31'd0, sbd1[3]}, (e == 4) ? 32'd1 : 32'd0);
      end
      step();
      chk("fast_busy", {31'd0, busy1[3]}, 32'd1);
      serial_in[3] = 1'b1;
      repeat (6) step();
      serial_in[3] = 1'b0;
      repeat (3) step();
      frame_done[3] = 1'b1;
      step();
      frame_done[3] = 1'b0;
      repeat (10) begin
         step();
         chk("fd_edge_drop", {30'd0, sbd1[3] | busy1[3], sbd0[3] | busy0[3]}, 32'd0);
      end
      serial_in = 4'hF;
      repeat (4) step();

      // random line activity
      for (int c = 0; c < 4; c++) rem[c] = 0;
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < 4; c++) begin
            if (rem[c] == 0) begin
               serial_in[c] = ~serial_in[c];
               rem[c] = (serial_in[c] == 1'b0) ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 6));
            end
            rem[c]--;
            enable[c]     = ($urandom_range(0, 19) != 0);
            frame_done[c] = ($urandom_range(0, 9) == 0);
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
